// File: rtl/branch_pkg.sv
// Shared constants and helpers for the branch unit:
// funct3 codes, 2-bit predictor states, saturating steps.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic cond_true;
    logic reserved;
  } cmp_res_t;

  function automatic logic [1:0] sat_inc2(
    input logic [1:0] s
  );
    return (s == ST) ? ST : s + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec2(
    input logic [1:0] s
  );
    return (s == SNT) ? SNT : s - 2'd1;
  endfunction

endpackage

// File: rtl/branch_unit_bht_if.sv
// Fetch-lookup and execute-resolve bundle of the branch unit.
// slave: the branch unit; master: the pipeline driving it.
interface branch_unit_bht_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  logic [XLEN-1:0]  fetch_pc_i;
  logic             pred_taken_o;
  logic             ex_valid_i;
  logic [XLEN-1:0]  ex_pc_i;
  logic             branch_i;
  logic             jump_i;
  logic [2:0]       func3_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic             ex_pred_taken_i;
  logic             taken_o;
  logic             mispredict_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  modport slave (
    input  fetch_pc_i,
    input  ex_valid_i,
    input  ex_pc_i,
    input  branch_i,
    input  jump_i,
    input  func3_i,
    input  rs1_i,
    input  rs2_i,
    input  ex_pred_taken_i,
    output pred_taken_o,
    output taken_o,
    output mispredict_o,
    output branch_cnt_o,
    output mispred_cnt_o
  );

  modport master (
    output fetch_pc_i,
    output ex_valid_i,
    output ex_pc_i,
    output branch_i,
    output jump_i,
    output func3_i,
    output rs1_i,
    output rs2_i,
    output ex_pred_taken_i,
    input  pred_taken_o,
    input  taken_o,
    input  mispredict_o,
    input  branch_cnt_o,
    input  mispred_cnt_o
  );

endinterface

// File: rtl/branch_compare.sv
// Combinational funct3 comparator on rs1/rs2.
// Ports: func3_i, rs1_i, rs2_i in; cond_true_o, reserved_o out.
module branch_compare
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            cond_true_o,
  output logic            reserved_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_i == rs2_i);
  assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
  assign lt_u = (rs1_i < rs2_i);

  // Reserved codes resolve not-taken so nothing X leaks out.
  always_comb begin
    cond_true_o = 1'b0;
    reserved_o  = 1'b0;
    unique case (1'b1)
      (func3_i == F3_BEQ):  cond_true_o = eq;
      (func3_i == F3_BNE):  cond_true_o = ~eq;
      (func3_i == F3_BLT):  cond_true_o = lt_s;
      (func3_i == F3_BGE):  cond_true_o = ~lt_s;
      (func3_i == F3_BLTU): cond_true_o = lt_u;
      (func3_i == F3_BGEU): cond_true_o = ~lt_u;
      default:              reserved_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit_bht.sv
// Branch resolution with a 2-bit-counter BHT and perf counters.
// Ports: clk, reset (async, active-high), bus (slave side).
module branch_unit_bht
  import branch_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] INIT_STATE  = 2'b01,
  parameter int         CNT_W       = 32
) (
  input logic             clk,
  input logic             reset,
  branch_unit_bht_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] e_idx;
  logic             cond_true;
  logic             reserved;
  logic             is_br;
  logic             taken;
  logic             mispredict;
  logic             upd;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mp_cnt;
  logic             unused_pc_bits;

  assign f_idx = bus.fetch_pc_i[IDX_W+1:2];
  assign e_idx = bus.ex_pc_i[IDX_W+1:2];

  assign unused_pc_bits = ^{
    bus.fetch_pc_i[XLEN-1:IDX_W+2],
    bus.fetch_pc_i[1:0],
    bus.ex_pc_i[XLEN-1:IDX_W+2],
    bus.ex_pc_i[1:0]
  };

  // Lookup reads the registered array: no bypass from
  // a same-cycle update.
  assign bus.pred_taken_o = bht[f_idx][1];

  branch_compare #(
    .XLEN (XLEN)
  ) u_cmp (
    .func3_i     (bus.func3_i),
    .rs1_i       (bus.rs1_i),
    .rs2_i       (bus.rs2_i),
    .cond_true_o (cond_true),
    .reserved_o  (reserved)
  );

  // Jump wins over branch when both are flagged.
  always_comb begin
    is_br      = 1'b0;
    taken      = 1'b0;
    mispredict = 1'b0;
    upd        = 1'b0;
    if (bus.ex_valid_i) begin
      is_br = bus.branch_i & ~bus.jump_i;
      taken = bus.jump_i | (bus.branch_i & cond_true);
      mispredict = is_br & (taken ^ bus.ex_pred_taken_i);
      upd = is_br & ~reserved;
    end
  end

  assign bus.taken_o      = taken;
  assign bus.mispredict_o = mispredict;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= INIT_STATE;
      end
    end else if (upd) begin
      bht[e_idx] <= taken ? sat_inc2(bht[e_idx])
                          : sat_dec2(bht[e_idx]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (upd) begin
      if (br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
      if (mispredict && mp_cnt != '1)
        mp_cnt <= mp_cnt + CNT_W'(1);
    end
  end

  assign bus.branch_cnt_o  = br_cnt;
  assign bus.mispred_cnt_o = mp_cnt;

endmodule

// File: tb/tb_branch_unit_bht.sv
// Randomized + directed bench for branch_unit_bht.
// Reference model uses plain integer counters per entry.
module tb_branch_unit_bht;

  localparam int XLEN  = 32;
  localparam int ENT   = 64;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_unit_bht_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_unit_bht #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (ENT),
    .INIT_STATE  (2'b01),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  int mb [ENT];
  int m_br;
  int m_mis;

  task automatic chk(input string nm, input logic [63:0] got,
                     input longint exp);
    checks++;
    if (got !== 64'(exp)) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic bit m_cond(input logic [2:0] f3,
                                input logic [31:0] a,
                                input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_taken();
    if (!bus.ex_valid_i) return 1'b0;
    if (bus.jump_i) return 1'b1;
    if (bus.branch_i)
      return m_cond(bus.func3_i, bus.rs1_i, bus.rs2_i);
    return 1'b0;
  endfunction

  function automatic bit m_misp();
    if (bus.ex_valid_i && bus.branch_i && !bus.jump_i)
      return m_taken() ^ bus.ex_pred_taken_i;
    return 1'b0;
  endfunction

  function automatic bit m_upd();
    return bus.ex_valid_i && bus.branch_i && !bus.jump_i
        && bus.func3_i != 3'd2 && bus.func3_i != 3'd3;
  endfunction

  task automatic mreset();
    for (int i = 0; i < ENT; i++) mb[i] = 1;
    m_br  = 0;
    m_mis = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mreset();
    end else if (m_upd()) begin
      int i;
      i = midx(bus.ex_pc_i);
      if (m_taken()) mb[i] = (mb[i] < 3) ? mb[i] + 1 : 3;
      else           mb[i] = (mb[i] > 0) ? mb[i] - 1 : 0;
      if (m_br < CMAX) m_br++;
      if (m_misp() && m_mis < CMAX) m_mis++;
    end
  end

  always @(negedge clk) begin
    chk("pred", bus.pred_taken_o,
        longint'(mb[midx(bus.fetch_pc_i)] >= 2));
    chk("taken", bus.taken_o, longint'(m_taken()));
    chk("mispredict", bus.mispredict_o, longint'(m_misp()));
    chk("branch_cnt", bus.branch_cnt_o, m_br);
    chk("mispred_cnt", bus.mispred_cnt_o, m_mis);
  end

  task automatic drv(input bit v, input logic [31:0] pc,
                     input bit br, input bit jp,
                     input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b,
                     input bit pp);
    bus.ex_valid_i      = v;
    bus.ex_pc_i         = pc;
    bus.branch_i        = br;
    bus.jump_i          = jp;
    bus.func3_i         = f3;
    bus.rs1_i           = a;
    bus.rs2_i           = b;
    bus.ex_pred_taken_i = pp;
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_step();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    bus.fetch_pc_i = $urandom & 32'h3FF;
    drv($urandom_range(0, 9) < 8, $urandom & 32'h3FF,
        $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
        3'($urandom_range(0, 7)), a, b, 1'($urandom));
  endtask

  logic [2:0] op_f3  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
  bit         op_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    mreset();
    reset = 1'b1;
    bus.fetch_pc_i = 32'h100;
    idle();
    repeat (2) @(posedge clk);
    #3;
    chk("rst_pred", bus.pred_taken_o, 0);
    chk("rst_bcnt", bus.branch_cnt_o, 0);
    chk("rst_mcnt", bus.mispred_cnt_o, 0);
    tick();
    reset = 1'b0;

    drv(1, 32'h200, 1, 0, 3'd0, 32'd5, 32'd5, 0);
    #2;
    chk("beq_pred", bus.pred_taken_o, 0);
    chk("beq_taken", bus.taken_o, 1);
    chk("beq_mis", bus.mispredict_o, 1);
    tick();
    idle();
    #2;
    chk("beq_bcnt", bus.branch_cnt_o, 1);
    chk("beq_mcnt", bus.mispred_cnt_o, 1);
    tick();

    for (int k = 0; k < 4; k++) begin
      drv(1, 32'h300, 1, 0, op_f3[k], 32'hFFFF_FFFF, 32'd1, 0);
      #2;
      chk($sformatf("op_f3_%0d", op_f3[k]), bus.taken_o,
          longint'(op_exp[k]));
      tick();
    end
    idle();
    #2;
    chk("op_bcnt", bus.branch_cnt_o, 5);
    chk("op_mcnt", bus.mispred_cnt_o, 3);
    tick();

    bus.fetch_pc_i = 32'h40;
    drv(1, 32'h40, 1, 0, 3'd0, 32'd7, 32'd7, 0);
    #2;
    chk("train0_pred", bus.pred_taken_o, 0);
    tick();
    idle();
    #2;
    chk("train1_pred", bus.pred_taken_o, 1);
    tick();
    repeat (2) begin
      drv(1, 32'h40, 1, 0, 3'd0, 32'd7, 32'd7, 1);
      tick();
    end
    drv(1, 32'h40, 1, 0, 3'd1, 32'd7, 32'd7, 1);
    tick();
    idle();
    #2;
    chk("train_nt_pred", bus.pred_taken_o, 1);
    chk("train_bcnt", bus.branch_cnt_o, 9);
    chk("train_mcnt", bus.mispred_cnt_o, 5);

    bus.fetch_pc_i = 32'h140;
    #1;
    chk("alias_rd_pred", bus.pred_taken_o, 1);
    tick();
    drv(1, 32'h140, 1, 0, 3'd1, 32'd3, 32'd3, 1);
    tick();
    idle();
    bus.fetch_pc_i = 32'h40;
    #2;
    chk("alias_wr_pred", bus.pred_taken_o, 0);
    tick();

    drv(1, 32'h40, 1, 0, 3'd0, 32'd9, 32'd9, 0);
    #2;
    chk("same_cyc_now", bus.pred_taken_o, 0);
    tick();
    idle();
    #2;
    chk("same_cyc_next", bus.pred_taken_o, 1);
    tick();

    drv(1, 32'h40, 1, 1, 3'd0, 32'd1, 32'd2, 0);
    #2;
    chk("jal_taken", bus.taken_o, 1);
    chk("jal_mis", bus.mispredict_o, 0);
    tick();
    drv(1, 32'h40, 1, 0, 3'd2, 32'd4, 32'd4, 1);
    #2;
    chk("rsv_taken", bus.taken_o, 0);
    chk("rsv_mis", bus.mispredict_o, 1);
    tick();
    idle();
    #2;
    chk("nochg_bcnt", bus.branch_cnt_o, 11);
    chk("nochg_mcnt", bus.mispred_cnt_o, 7);
    chk("nochg_pred", bus.pred_taken_o, 1);
    tick();

    repeat (3000) begin
      rnd_step();
      tick();
    end

    #2;
    reset = 1'b1;
    #1;
    chk("midrst_bcnt", bus.branch_cnt_o, 0);
    chk("midrst_mcnt", bus.mispred_cnt_o, 0);
    for (int k = 0; k < 8; k++) begin
      bus.fetch_pc_i = 32'(k * 36);
      #1;
      chk($sformatf("midrst_pred_%0d", k), bus.pred_taken_o, 0);
    end
    tick();
    reset = 1'b0;

    repeat (300) begin
      rnd_step();
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
